// File: rtl/interp_pkg.sv
// Shared defaults and index helpers for the interpolation window buffer.
// Used by both the RTL and the bench so the window layout has one definition.
package interp_pkg;

    localparam int unsigned PIX_W_DEFAULT = 8;
    localparam int unsigned COLS_DEFAULT  = 8;
    localparam int unsigned ROWS_DEFAULT  = 15;

    // Bits needed to count 0..rows inclusive.
    function automatic int unsigned fill_width(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

    // Pixel slot in the flattened window for pixel c of row r.
    function automatic int unsigned idx(input int unsigned r,
                                        input int unsigned c,
                                        input bit          transpose,
                                        input int unsigned rows = ROWS_DEFAULT,
                                        input int unsigned cols = COLS_DEFAULT);
        return transpose ? (c * rows + r) : (r * cols + c);
    endfunction

endpackage

// File: rtl/row_shift_array.sv
// ROWS-deep shift register of full pixel rows; row 0 is the newest.
// Clear has priority over shift.
module row_shift_array
    import interp_pkg::*;
#(
    parameter int unsigned ROW_W = PIX_W_DEFAULT * COLS_DEFAULT,
    parameter int unsigned ROWS  = ROWS_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       shift_i,
    input  logic [ROW_W-1:0]           row_i,
    output logic [ROWS-1:0][ROW_W-1:0] rows_o
);

    logic [ROWS-1:0][ROW_W-1:0] rows_q, rows_d;

    always_comb begin
        rows_d = rows_q;
        if (clear_i) begin
            rows_d = '0;
        end else if (shift_i) begin
            rows_d[0] = row_i;
            for (int r = 1; r < int'(ROWS); r++) begin
                rows_d[r] = rows_q[r-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q <= '0;
        end else begin
            rows_q <= rows_d;
        end
    end

    assign rows_o = rows_q;

endmodule

// File: rtl/transposing_window_buffer.sv
// Row window buffer for the sub-pixel interpolation filters: keeps the last ROWS rows
// and presents them row- or column-major with valid/ready handshakes on both sides.
module transposing_window_buffer
    import interp_pkg::*;
#(
    parameter int unsigned PIX_W     = PIX_W_DEFAULT,
    parameter int unsigned COLS      = COLS_DEFAULT,
    parameter int unsigned ROWS      = ROWS_DEFAULT,
    parameter bit          TRANSPOSE = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_L,
    input  logic                          flush,
    input  logic                          slide,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [COLS*PIX_W-1:0]         in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROWS*COLS*PIX_W-1:0]    out_win,
    output logic [fill_width(ROWS)-1:0]   fill
);

    localparam int unsigned       FILL_W = fill_width(ROWS);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(ROWS);

    logic [FILL_W-1:0]                fill_q, fill_d;
    logic                             in_acc, out_acc;
    logic [ROWS-1:0][COLS*PIX_W-1:0]  rows;

    assign out_valid = (fill_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    // Flush wins over both handshakes; an offered row that cycle is dropped.
    assign in_acc    = in_valid && in_ready && !flush;
    assign out_acc   = out_valid && out_ready && !flush;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (out_acc) begin
            if (slide) begin
                fill_d = in_acc ? FULL : FILL_W'(ROWS - 1);
            end else begin
                fill_d = in_acc ? FILL_W'(1) : '0;
            end
        end else if (in_acc && fill_q != FULL) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

    row_shift_array #(
        .ROW_W (COLS * PIX_W),
        .ROWS  (ROWS)
    ) u_rows (
        .clk_i   (clock),
        .rst_ni  (reset_L),
        .clear_i (flush),
        .shift_i (in_acc),
        .row_i   (in_row),
        .rows_o  (rows)
    );

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        for (genvar c = 0; c < int'(COLS); c++) begin : g_col
            assign out_win[idx(r, c, TRANSPOSE, ROWS, COLS)*PIX_W +: PIX_W] =
                rows[r][c*PIX_W +: PIX_W];
        end
    end

endmodule
